// File: rtl/uart_rx_mem_if.sv
// Core-side load bus for the UART receive buffer: address/enable from the core,
// load data and status flags back to it.
interface uart_rx_mem_if;
  logic [31:0] i_addr;
  logic        i_read_en;
  logic [31:0] o_data;
  logic        o_rx_ready;
  logic        o_overrun;

  modport master (
    output i_addr, i_read_en,
    input  o_data, o_rx_ready, o_overrun
  );

  modport slave (
    input  i_addr, i_read_en,
    output o_data, o_rx_ready, o_overrun
  );
endinterface

// File: rtl/uart_rx_mem.sv
// UART receiver that packs 4 bytes per 32-bit word into a FIFO read through two load addresses.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity error flag in status bit 4.
module uart_rx_mem #(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_rx,
  uart_rx_mem_if.slave bus
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] HALF_BIT  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_BIT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [31:0]      STAT_ADDR = BASE_ADDR + 32'd4;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic rx_meta_reg, rx_sync_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
    end else begin
      rx_meta_reg <= i_rx;
      rx_sync_reg <= rx_meta_reg;
    end
  end

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;
  logic [1:0]       byte_cnt_reg;
  logic             push_reg;
  logic             bit_tick, par_ok, frame_evt, byte_ok;

  assign bit_tick  = (cnt_reg == '0);
  assign frame_evt = (state_reg == STOP) && bit_tick && !rx_sync_reg;
  assign byte_ok   = (state_reg == STOP) && bit_tick && rx_sync_reg && par_ok;

`ifdef UART_RX_PARITY_EN
  logic par_ok_reg, par_evt;
  assign par_ok  = par_ok_reg;
  assign par_evt = (state_reg == PARITY) && bit_tick && (rx_sync_reg != ^shift_reg);
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      byte_cnt_reg <= '0;
      push_reg     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_ok_reg   <= 1'b0;
`endif
    end else begin
      push_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!rx_sync_reg) begin
            cnt_reg   <= HALF_BIT;
            state_reg <= START;
          end
        end
        START: begin
          if (!bit_tick) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end else if (rx_sync_reg) begin
            state_reg <= IDLE;  // line bounced back high: glitch, not a start bit
          end else begin
            cnt_reg     <= FULL_BIT;
            bit_idx_reg <= '0;
            state_reg   <= DATA;
          end
        end
        DATA: begin
          if (!bit_tick) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end else begin
            shift_reg   <= {rx_sync_reg, shift_reg[7:1]};
            bit_idx_reg <= bit_idx_reg + 3'd1;
            cnt_reg     <= FULL_BIT;
            if (bit_idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_reg <= PARITY;
`else
              state_reg <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (!bit_tick) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end else begin
            par_ok_reg <= (rx_sync_reg == ^shift_reg);
            cnt_reg    <= FULL_BIT;
            state_reg  <= STOP;
          end
        end
`endif
        STOP: begin
          if (!bit_tick) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end else begin
            if (byte_ok) begin
              byte_cnt_reg <= byte_cnt_reg + 2'd1;
              push_reg     <= (byte_cnt_reg == 2'd3);
            end
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Little-endian packing: byte lane gi captures the byte received when byte_cnt == gi.
  logic [31:0] word;
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_reg;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        lane_reg <= '0;
      end else if (byte_ok && byte_cnt_reg == 2'(gi)) begin
        lane_reg <= shift_reg;
      end
    end
    assign word[gi*8 +: 8] = lane_reg;
  end

  logic [31:0]      mem_reg [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   count_reg, count_next;
  logic             rx_ready_reg, overrun_reg, frame_err_reg;
  logic             full, not_empty, data_rd, stat_rd, pop, push_ok, overrun_evt;

  assign full        = (count_reg == (PTR_W+1)'(FIFO_DEPTH));
  assign not_empty   = (count_reg != '0);
  assign data_rd     = bus.i_read_en && (bus.i_addr == BASE_ADDR);
  assign stat_rd     = bus.i_read_en && (bus.i_addr == STAT_ADDR);
  assign pop         = data_rd && not_empty;
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign push_ok     = push_reg && (!full || pop);
  assign overrun_evt = push_reg && full && !pop;

  always_ff @(posedge i_clk) begin
    if (push_ok) mem_reg[wr_ptr_reg] <= word;
  end

  always_comb begin
    count_next = count_reg;
    if (push_ok && !pop)      count_next = count_reg + (PTR_W+1)'(1);
    else if (pop && !push_ok) count_next = count_reg - (PTR_W+1)'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      rx_ready_reg  <= 1'b0;
      overrun_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg     <= count_next;
      rx_ready_reg  <= (count_next != '0);
      // Set events beat the clear-on-read of the status register.
      overrun_reg   <= overrun_evt | (overrun_reg & ~stat_rd);
      frame_err_reg <= frame_evt | (frame_err_reg & ~stat_rd);
    end
  end

  logic [31:0] status;
`ifdef UART_RX_PARITY_EN
  logic parity_err_reg;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) parity_err_reg <= 1'b0;
    else          parity_err_reg <= par_evt | (parity_err_reg & ~stat_rd);
  end
  assign status = {27'b0, parity_err_reg, frame_err_reg, overrun_reg, full, not_empty};
`else
  assign status = {28'b0, frame_err_reg, overrun_reg, full, not_empty};
`endif

  always_comb begin
    bus.o_data = '0;
    if (data_rd && not_empty) bus.o_data = mem_reg[rd_ptr_reg];
    else if (stat_rd)         bus.o_data = status;
  end

  assign bus.o_rx_ready = rx_ready_reg;
  assign bus.o_overrun  = overrun_reg;
endmodule

// File: doc/uart_rx_mem.md
Name: uart_rx_mem

Overview:
- Inbound (host-to-core) UART path: deserialises 8N1 serial bytes from an external line and packs four bytes into one 32-bit word.
- Buffers words in a FIFO and exposes them to the single-cycle core as memory-mapped load addresses (data register and status register).
- The outbound path writes core data to memory and serialises it; this block is its counterpart, so programs can poll and load received data.

Parameters:
- CLKS_PER_BIT, 16, i_clk cycles per UART bit (even, >= 4).
- FIFO_DEPTH, 8, FIFO depth in 32-bit words (power of two, >= 2).
- BASE_ADDR, 32'h0000_0100, byte address of the data register; the status register is at BASE_ADDR+4.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_rx  in  1  serial input, idle high, asynchronous to i_clk.
- i_addr  in  32  load address from the core ALU result.
- i_read_en  in  1  core memory-read enable.
- o_data  out  32  load data to the core's mem-to-reg mux.
- o_rx_ready  out  1  FIFO not empty.
- o_overrun  out  1  sticky overrun flag.

Behaviour:
- Reset (async, i_rst_n=0):
  - FSM goes to IDLE; FIFO empty; pointers and count = 0.
  - Byte counter = 0; partial word discarded.
  - Sticky flags = 0; o_rx_ready = 0; o_overrun = 0.
  - Synchroniser flops = 1.
  - Reset mid-frame or mid-word discards all partial data.
- Input synchronisation: i_rx passes through a 2-FF synchroniser. All FSM decisions use the synchronised value.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on synchronised rx = 0 (falling edge), load the bit counter with CLKS_PER_BIT/2-1 and go to START.
  - START: at counter expiry, sample rx.
    - 1: false start, return to IDLE with no side effects.
    - 0: reload CLKS_PER_BIT-1 and go to DATA.
  - DATA: sample at each counter expiry (mid-bit); 8 bits, LSB first, shifted into the byte register; after the 8th bit go to STOP.
  - STOP: sample at counter expiry.
    - 1: byte valid.
    - 0: framing error; byte discarded, byte counter unchanged, sticky frame_err set.
    - Either way, go to IDLE. A new falling edge is accepted from the cycle after.
- Word packing: little-endian, first byte to [7:0], fourth byte to [31:24]. The byte counter wraps 3 -> 0. On the 4th valid byte, the word is pushed on the next rising edge.
- Latency: o_rx_ready rises 2 cycles after the final STOP sample cycle (1 cycle to push, 1 registered output).
- Read decode is combinational:
  - i_read_en=1, i_addr=BASE_ADDR: o_data = FIFO head, or 0 if empty.
  - i_read_en=1, i_addr=BASE_ADDR+4: o_data = {28'b0, frame_err, overrun, full, not_empty}.
  - Any other address or i_read_en=0: o_data = 0.
- Pop: at the rising edge ending a data-register read when not empty. Reading when empty causes no pop and no flag change.
- Status read side-effect: clears overrun and frame_err at the ending edge (clear-on-read). A flag event in the same cycle wins, and the flag stays 1.
- Push when full: the word is dropped and overrun set, unless a pop occurs in the same cycle. In that case push and pop both proceed, count is unchanged and no overrun occurs.
- Simultaneous push and pop when not full: count unchanged.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally; count is log2(FIFO_DEPTH)+1 bits.
- o_rx_ready and o_overrun are registered.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- When defined:
  - Frame is 8E1; the FSM gains a PARITY state between DATA and STOP, sampled mid-bit.
  - Parity mismatch: byte discarded, sticky parity_err set. It is visible in status bit 4 and cleared on status read like the other flags.
- When undefined: there is no PARITY state, status bit 4 reads 0, and the frame is 8N1 as above.

Test Plan:
- Reset then send bytes 0x44,0x33,0x22,0x11 (CLKS_PER_BIT=16) -> o_rx_ready=1 two cycles after the 4th STOP sample. Load BASE_ADDR returns 32'h11223344; o_rx_ready=0 next cycle.
- Glitch: rx low for 4 cycles in IDLE -> false start, no byte counted. A following 4-byte frame sequence yields the correct word.
- Stop bit forced 0 on byte 2 of 0xAA,0xBB,0xCC,0xDD,0xEE -> status = 32'h9 (frame_err, not_empty); word = 32'hEEDDCCAA. A second status read returns 32'h1.
- Fill the FIFO with 8 words, then send a 9th word -> status = 32'h7 and o_overrun=1. The 9th word is lost; the 8 loads return words 1..8 in order.
- Assert i_rst_n=0 mid-DATA of byte 3 -> all outputs 0 immediately. After release, 4 new bytes form one clean word.
- The 4th-byte push coincides with a data-register pop at full -> count stays 8, no overrun; the new word is the last entry.
